// File: rtl/cpu_pkg.sv
//==============================================================================
// cpu_pkg -- shared widths, instruction constants and fetch state encoding
// Rev 1.0
//==============================================================================
`default_nettype none

package cpu_pkg;

  localparam int PC_WIDTH    = 22;
  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = 32'h7800_0000;

  // Opcode lives in the top five instruction bits; BUBBLE_INSTR decodes as NOP.
  localparam logic [4:0] OPC_ADD = 5'h00;
  localparam logic [4:0] OPC_SUB = 5'h01;
  localparam logic [4:0] OPC_LD  = 5'h08;
  localparam logic [4:0] OPC_ST  = 5'h09;
  localparam logic [4:0] OPC_NOP = 5'h0F;
  localparam logic [4:0] OPC_BR  = 5'h10;
  localparam logic [4:0] OPC_HLT = 5'h1F;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    REDIRECT = 2'd1,
    HALTED   = 2'd2
  } fetch_state_e;

  function automatic logic [4:0] opcode_of(input logic [INSTR_WIDTH-1:0] i_word);
    return i_word[31:27];
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_skid_buf.sv
//==============================================================================
// instr_skid_buf -- one-entry holding register for an instruction returned
// while decode is stalled. Rev 1.0
//==============================================================================
`default_nettype none

import cpu_pkg::*;

module instr_skid_buf (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_capture,
  input  logic                   i_flush,
  input  logic [INSTR_WIDTH-1:0] i_data,
  input  logic [PC_WIDTH-1:0]    i_pc,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_data,
  output logic [PC_WIDTH-1:0]    o_pc
);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      o_valid <= 1'b0;
      o_data  <= BUBBLE_INSTR;
      o_pc    <= '0;
    end else if (i_capture) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_pc    <= i_pc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//==============================================================================
// instr_fetch -- sequential fetch with stall skid, branch redirect and halt.
// Optional IF_PERF_CNT_EN adds fetch/bubble counters. Rev 1.0
//==============================================================================
`default_nettype none

import cpu_pkg::*;

module instr_fetch (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   hlt,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_rd_en,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    PC_out,
  output logic                   instr_valid,
`ifdef IF_PERF_CNT_EN
  output logic                   halted,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            bubble_cnt
`else
  output logic                   halted
`endif
);

  fetch_state_e           r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic                   r_infl_valid;
  logic [PC_WIDTH-1:0]    r_infl_pc;

  logic                   w_active;
  logic                   w_issue;
  logic                   w_halt_req;
  logic                   w_capture;
  logic                   w_flush;
  logic [PC_WIDTH-1:0]    w_next_addr;
  logic                   w_skid_valid;
  logic [INSTR_WIDTH-1:0] w_skid_data;
  logic [PC_WIDTH-1:0]    w_skid_pc;

  // The branch target bypasses r_pc so the target is read in the redirect
  // cycle itself, limiting the squash to a single bubble.
  assign w_active    = (r_state != HALTED);
  assign w_next_addr = branch_taken ? branch_target : r_pc;
  assign imem_addr   = rst ? '0 : w_next_addr;
  assign imem_rd_en  = !rst && w_active;

  assign w_issue    = w_active && (branch_taken || !stall);
  assign w_halt_req = (r_state == FETCH) && hlt && instr_valid && !stall && !branch_taken;
  assign w_capture  = w_active && stall && !branch_taken && r_infl_valid;
  assign w_flush    = branch_taken || w_halt_req || (!stall && w_skid_valid);

  instr_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_flush   (w_flush),
    .i_data    (imem_data),
    .i_pc      (r_infl_pc),
    .o_valid   (w_skid_valid),
    .o_data    (w_skid_data),
    .o_pc      (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= '0;
      r_infl_valid <= 1'b0;
      r_infl_pc    <= '0;
      instr        <= BUBBLE_INSTR;
      PC_out       <= '0;
      instr_valid  <= 1'b0;
      halted       <= 1'b0;
    end else begin
      r_infl_valid <= w_issue;
      r_infl_pc    <= w_next_addr;
      case (r_state)
        FETCH, REDIRECT: begin
          r_state <= FETCH;
          if (branch_taken) begin
            r_state     <= REDIRECT;
            r_pc        <= branch_target + PC_WIDTH'(1);
            instr       <= BUBBLE_INSTR;
            instr_valid <= 1'b0;
          end else if (stall) begin
            r_pc <= r_pc;
          end else if (w_halt_req) begin
            r_state     <= HALTED;
            instr       <= BUBBLE_INSTR;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end else begin
            r_pc <= r_pc + PC_WIDTH'(1);
            if (w_skid_valid) begin
              instr       <= w_skid_data;
              PC_out      <= w_skid_pc;
              instr_valid <= 1'b1;
            end else if (r_infl_valid) begin
              instr       <= imem_data;
              PC_out      <= r_infl_pc;
              instr_valid <= 1'b1;
            end else begin
              instr       <= BUBBLE_INSTR;
              instr_valid <= 1'b0;
            end
          end
        end
        default: begin
          instr       <= BUBBLE_INSTR;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (instr_valid && !stall) fetch_cnt <= fetch_cnt + 32'd1;
      if (!instr_valid && (r_state != HALTED)) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//==============================================================================
// tb_instr_fetch -- directed bench for instr_fetch; memory returns word=address.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [21:0] branch_target = '0;
  logic        hlt = 1'b0;
  logic [21:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data = '0;
  logic [31:0] instr;
  logic [21:0] PC_out;
  logic        instr_valid;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .hlt           (hlt),
    .imem_addr     (imem_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_data     (imem_data),
    .instr         (instr),
    .PC_out        (PC_out),
    .instr_valid   (instr_valid),
`ifdef IF_PERF_CNT_EN
    .halted        (halted),
    .fetch_cnt     (fetch_cnt),
    .bubble_cnt    (bubble_cnt)
`else
    .halted        (halted)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= {10'd0, imem_addr};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input string tag, input logic [21:0] pc);
    check_eq({tag, "_pc"}, 32'(PC_out), 32'(pc));
    check_eq({tag, "_instr"}, instr, {10'd0, pc});
    check_eq({tag, "_vld"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic expect_bubble(input string tag);
    check_eq({tag, "_instr"}, instr, 32'h7800_0000);
    check_eq({tag, "_vld"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    // reset held for two edges
    tick();
    check_eq("rst_rd_en", 32'(imem_rd_en), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_pc_out", 32'(PC_out), 32'd0);
    expect_bubble("rst");
    tick();
    rst = 1'b0;
    #1;
    check_eq("rel_rd_en", 32'(imem_rd_en), 32'd1);
    check_eq("rel_addr", 32'(imem_addr), 32'd0);
    tick();
    expect_bubble("rel_c1");
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_instr($sformatf("seq%0d", i), 22'(i));
    end

    // stall for three cycles at PC_out=5
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_instr($sformatf("stall%0d", i), 22'd5);
    end
    stall = 1'b0;
    for (int i = 6; i <= 10; i++) begin
      tick();
      expect_instr($sformatf("post_stall%0d", i), 22'(i));
    end

    // branch to 0x100 at PC_out=10
    branch_taken  = 1'b1;
    branch_target = 22'h100;
    #1;
    check_eq("br_addr", 32'(imem_addr), 32'h100);
    tick();
    branch_taken = 1'b0;
    expect_bubble("br_bubble");
    tick();
    expect_instr("br_tgt", 22'h100);
    tick();
    expect_instr("br_tgt1", 22'h101);

    // stall, then stall together with branch: redirect wins
    stall = 1'b1;
    tick();
    expect_instr("pre_sb_hold", 22'h101);
    branch_taken  = 1'b1;
    branch_target = 22'h20;
    tick();
    stall        = 1'b0;
    branch_taken = 1'b0;
    expect_bubble("sb_bubble");
    tick();
    expect_instr("sb_tgt", 22'h20);
    tick();
    expect_instr("sb_tgt1", 22'h21);

    // wrap of the 22-bit PC
    branch_taken  = 1'b1;
    branch_target = 22'h3FFFFE;
    tick();
    branch_taken = 1'b0;
    expect_bubble("wrap_bubble");
    tick();
    expect_instr("wrap0", 22'h3FFFFE);
    tick();
    expect_instr("wrap1", 22'h3FFFFF);
    tick();
    expect_instr("wrap2", 22'h000000);
    tick();
    expect_instr("wrap3", 22'h000001);

    // branch coinciding with a qualifying halt: branch taken, no halt
    hlt           = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 22'h5;
    tick();
    hlt          = 1'b0;
    branch_taken = 1'b0;
    check_eq("bh_halted", 32'(halted), 32'd0);
    expect_bubble("bh_bubble");
    for (int i = 5; i <= 7; i++) begin
      tick();
      expect_instr($sformatf("bh_seq%0d", i), 22'(i));
    end

    // halt on the instruction at PC_out=7
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    check_eq("hlt_halted", 32'(halted), 32'd1);
    check_eq("hlt_rd_en", 32'(imem_rd_en), 32'd0);
    expect_bubble("hlt");
    for (int i = 0; i < 10; i++) begin
      branch_taken = (i == 2);
      tick();
      check_eq($sformatf("hold_halted%0d", i), 32'(halted), 32'd1);
      check_eq($sformatf("hold_rd_en%0d", i), 32'(imem_rd_en), 32'd0);
      check_eq($sformatf("hold_vld%0d", i), 32'(instr_valid), 32'd0);
    end
    branch_taken = 1'b0;

    // reset restarts fetch at 0
    rst = 1'b1;
    tick();
    check_eq("rst2_halted", 32'(halted), 32'd0);
    check_eq("rst2_rd_en", 32'(imem_rd_en), 32'd0);
    check_eq("rst2_pc_out", 32'(PC_out), 32'd0);
    expect_bubble("rst2");
    rst = 1'b0;
    #1;
    check_eq("rel2_rd_en", 32'(imem_rd_en), 32'd1);
    check_eq("rel2_addr", 32'(imem_addr), 32'd0);
    tick();
    expect_bubble("rel2_c1");
    tick();
    expect_instr("rel2_seq0", 22'd0);
    tick();
    expect_instr("rel2_seq1", 22'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
